// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the shared 3-to-8 decoder arbiter.
// The master side drives req/done; the slave (the arbiter) returns the grant.
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant_valid,
    input  grant_idx,
    input  grant_oh,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_valid,
    output grant_idx,
    output grant_oh,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters, with a hold timer
// bounding each grant. Includes a companion property checker instantiated by the top.
module decoder_rr_arbiter_chk #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             grant_valid,
  input logic [2:0]       grant_idx,
  input logic [7:0]       grant_oh,
  input logic             timeout,
  input logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  a_oh_matches_idx: assert property (@(posedge clk) disable iff (rst)
    grant_oh == (grant_valid ? (8'h01 << grant_idx) : 8'h00));

  a_timeout_in_dead_cycle: assert property (@(posedge clk) disable iff (rst)
    timeout |-> !grant_valid);

  // The decoder select must stay frozen for the whole life of a grant.
  a_select_stable: assert property (@(posedge clk) disable iff (rst)
    (grant_valid && $past(grant_valid)) |-> (grant_idx == $past(grant_idx)));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_LAST);
endmodule

module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input logic                  clk,
  input logic                  rst,
  decoder_rr_arbiter_if.slave  bus
);
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_r, state_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [2:0]       grant_idx_r, grant_idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             grant_valid_r, grant_valid_s;
  logic [7:0]       grant_oh_r, grant_oh_s;
  logic             timeout_r, timeout_s;
  logic             rel_done_s, rel_wd_s, rel_tmo_s;

  // First set request after 'last', wrapping 7->0; 'last' itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req_v, input logic [2:0] last);
    logic [2:0] pick;
    logic [2:0] cand;
    pick = last;
    for (int i = 8; i >= 1; i--) begin
      cand = last + 3'(i);
      if (req_v[cand]) begin
        pick = cand;
      end
    end
    return pick;
  endfunction

  function automatic logic [7:0] idx_to_oh(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Next-state and registered-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    cnt_s         = cnt_r;
    grant_idx_s   = grant_idx_r;
    grant_valid_s = 1'b0;
    grant_oh_s    = 8'h00;
    timeout_s     = 1'b0;
    rel_done_s    = bus.done;
    rel_wd_s      = !bus.req[grant_idx_r];
    rel_tmo_s     = (cnt_r == CNT_LAST);

    case (state_r)
      IDLE: begin
        if (bus.req != 8'h00) begin
          grant_idx_s   = rr_pick(bus.req, ptr_r);
          grant_valid_s = 1'b1;
          grant_oh_s    = idx_to_oh(grant_idx_s);
          cnt_s         = {CNT_W{1'b0}};
          state_s       = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (rel_done_s || rel_wd_s || rel_tmo_s) begin
          // Only a pure timer expiry is reported; done/withdrawal take priority.
          ptr_s     = grant_idx_r;
          state_s   = IDLE;
          timeout_s = !rel_done_s && !rel_wd_s;
        end else begin
          grant_valid_s = 1'b1;
          grant_oh_s    = idx_to_oh(grant_idx_r);
          cnt_s         = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= 3'd7;
      cnt_r         <= {CNT_W{1'b0}};
      grant_idx_r   <= 3'd0;
      grant_valid_r <= 1'b0;
      grant_oh_r    <= 8'h00;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      cnt_r         <= cnt_s;
      grant_idx_r   <= grant_idx_s;
      grant_valid_r <= grant_valid_s;
      grant_oh_r    <= grant_oh_s;
      timeout_r     <= timeout_s;
    end
  end

  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_idx   = grant_idx_r;
  assign bus.grant_oh    = grant_oh_r;
  assign bus.timeout     = timeout_r;

  decoder_rr_arbiter_chk #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .grant_valid (grant_valid_r),
    .grant_idx   (grant_idx_r),
    .grant_oh    (grant_oh_r),
    .timeout     (timeout_r),
    .cnt         (cnt_r)
  );
endmodule
